// File: rtl/gcd_engine.sv
// Iterative subtractive-Euclid GCD engine, one subtract per clock, with busy/done handshake.
// Define GCD_DEBUG_EN to expose the FSM state and live operand registers on extra ports.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = WIDTH + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in1,
  input  logic [WIDTH-1:0] data_in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [CNT_W-1:0] steps,
  output logic             zero_err
`ifdef GCD_DEBUG_EN
  ,
  output logic [3:0]       state_ctrl,
  output logic [WIDTH-1:0] a_reg_check,
  output logic [WIDTH-1:0] b_reg_check
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [CNT_W-1:0] cnt;

  logic             finish;
  logic [WIDTH-1:0] fin_result;
  logic             fin_zero;

  // Termination cases in priority order; anything else means another subtract step.
  always_comb begin
    finish     = 1'b0;
    fin_result = '0;
    fin_zero   = 1'b0;
    if (state == CALC) begin
      if (a_r == '0 && b_r == '0) begin
        finish   = 1'b1;
        fin_zero = 1'b1;
      end else if (a_r == '0) begin
        finish     = 1'b1;
        fin_result = b_r;
      end else if (b_r == '0 || a_r == b_r) begin
        finish     = 1'b1;
        fin_result = a_r;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      steps    <= '0;
      zero_err <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            a_r   <= data_in1;
            b_r   <= data_in2;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (finish) begin
            result   <= fin_result;
            zero_err <= fin_zero;
            steps    <= cnt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            done <= 1'b0;
            if (a_r > b_r) a_r <= a_r - b_r;
            else           b_r <= b_r - a_r;
            // Saturate rather than wrap so a huge step count never reads as small.
            if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GCD_DEBUG_EN
  assign state_ctrl  = (state == CALC) ? 4'd1 : 4'd0;
  assign a_reg_check = a_r;
  assign b_reg_check = b_r;
`endif

endmodule
